// File: rtl/wb_multi_bus_if.sv
// Multi-channel Wishbone master for MiniMIPS32: NCH CPU request channels share one bus port
// through fixed-priority or round-robin arbitration, with flush abort and an ack timeout.
module wb_multi_bus_if #(
  parameter int NCH       = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int PRIO_MODE = 0,
  parameter int TO_CYC    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic [NCH-1:0]        ch_ce_i,
  input  logic [NCH-1:0]        ch_we_i,
  input  logic [NCH*AW-1:0]     ch_addr_i,
  input  logic [NCH*DW-1:0]     ch_data_i,
  input  logic [NCH*(DW/8)-1:0] ch_sel_i,
  input  logic [NCH-1:0]        ch_hold_i,
  output logic [NCH*DW-1:0]     ch_data_o,
  output logic [NCH-1:0]        ch_err_o,
  output logic [NCH-1:0]        ch_stallreq_o,
  input  logic [DW-1:0]         wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  output logic [AW-1:0]         wb_adr_o,
  output logic [DW-1:0]         wb_dat_o,
  output logic                  wb_we_o,
  output logic [DW/8-1:0]       wb_sel_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o
);

  localparam int SW = DW / 8;
  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [NCH-1:0]    r_done;
  logic [NCH-1:0]    r_err;
  logic [NCH*DW-1:0] r_data;
  logic [GW-1:0]     r_g;
  logic [GW-1:0]     r_lastG;
  logic [15:0]       r_toCnt;
  logic [AW-1:0]     r_adr;
  logic [DW-1:0]     r_dat;
  logic              r_we;
  logic [SW-1:0]     r_sel;
  logic              r_cyc;
  logic              r_stb;

  logic [NCH-1:0]    w_req;
  logic [GW-1:0]     w_grant;
  logic              w_found;
  logic              w_timeout;
  logic              w_start;
  logic              w_term;
  logic              w_termErr;

  assign w_req         = ch_ce_i & ~r_done & {NCH{~flush_i}};
  assign ch_stallreq_o = ch_ce_i & ~r_done;
  assign w_timeout     = (TO_CYC != 0) && (r_toCnt == 16'(TO_CYC - 1));
  // A termination without ack can only be an error or the timeout; both return an error.
  assign w_termErr     = wb_err_i | ~wb_ack_i;

  assign ch_data_o = r_data;
  assign ch_err_o  = r_err;
  assign wb_adr_o  = r_adr;
  assign wb_dat_o  = r_dat;
  assign wb_we_o   = r_we;
  assign wb_sel_o  = r_sel;
  assign wb_stb_o  = r_stb;
  assign wb_cyc_o  = r_cyc;

  // Round-robin: requesters above last_g first, then wrap to the lowest index.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    if (PRIO_MODE == 0) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (w_req[i]) w_grant = GW'(i);
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!w_found && w_req[i] && (GW'(i) > r_lastG)) begin
          w_grant = GW'(i);
          w_found = 1'b1;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (!w_found && w_req[i]) begin
          w_grant = GW'(i);
          w_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    w_term      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          w_start     = 1'b1;
          w_nextState = S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush_i) begin
          w_nextState = S_IDLE;
        end else if (wb_ack_i || wb_err_i || w_timeout) begin
          w_term      = 1'b1;
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done  <= '0;
      r_err   <= '0;
      r_data  <= '0;
      r_g     <= '0;
      r_lastG <= GW'(NCH - 1);
      r_toCnt <= '0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
    end else begin
      // Completions stay latched until the consuming stage is no longer held.
      r_done <= r_done & ch_hold_i;
      r_err  <= r_err & ch_hold_i;
      if (flush_i) begin
        r_done <= '0;
        r_err  <= '0;
      end
      if (w_start) begin
        r_g     <= w_grant;
        r_lastG <= w_grant;
        r_adr   <= ch_addr_i[w_grant*AW +: AW];
        r_dat   <= ch_data_i[w_grant*DW +: DW];
        r_we    <= ch_we_i[w_grant];
        r_sel   <= ch_sel_i[w_grant*SW +: SW];
        r_cyc   <= 1'b1;
        r_stb   <= 1'b1;
        r_toCnt <= '0;
      end
      if (r_state == S_BUSY) begin
        r_toCnt <= r_toCnt + 16'd1;
        if (flush_i) begin
          r_cyc <= 1'b0;
          r_stb <= 1'b0;
        end else if (w_term) begin
          r_cyc        <= 1'b0;
          r_stb        <= 1'b0;
          r_done[r_g]  <= 1'b1;
          r_err[r_g]   <= w_termErr;
          if (w_termErr)  r_data[r_g*DW +: DW] <= '0;
          else if (!r_we) r_data[r_g*DW +: DW] <= wb_dat_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_multi_bus_if.sv
// Bench for wb_multi_bus_if: a fixed-priority and a round-robin instance, directed scenarios
// followed by randomized request rounds checked against a service-order/result model.
module tb_wb_multi_bus_if;

  localparam int NCH   = 3;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int TO    = 4;
  localparam int K_ACK = 0;
  localparam int K_ERR = 1;
  localparam int K_TO  = 2;

  logic clk;
  logic rst;
  logic              flush  [2];
  logic [NCH-1:0]    ce     [2];
  logic [NCH-1:0]    we     [2];
  logic [NCH*AW-1:0] addr   [2];
  logic [NCH*DW-1:0] wdata  [2];
  logic [NCH*SW-1:0] sel    [2];
  logic [NCH-1:0]    hold   [2];
  logic [NCH*DW-1:0] chDataO[2];
  logic [NCH-1:0]    chErrO [2];
  logic [NCH-1:0]    stallO [2];
  logic [DW-1:0]     wbDatI [2];
  logic              wbAck  [2];
  logic              wbErr  [2];
  logic [AW-1:0]     wbAdr  [2];
  logic [DW-1:0]     wbDatO [2];
  logic              wbWe   [2];
  logic [SW-1:0]     wbSel  [2];
  logic              wbStb  [2];
  logic              wbCyc  [2];

  int          compCnt;
  int          errCnt;
  int          lastServed [2];
  logic [DW-1:0] expData [2][NCH];

  wb_multi_bus_if #(.NCH(NCH), .AW(AW), .DW(DW), .PRIO_MODE(0), .TO_CYC(TO)) dutFix (
    .clk(clk), .rst(rst), .flush_i(flush[0]),
    .ch_ce_i(ce[0]), .ch_we_i(we[0]), .ch_addr_i(addr[0]), .ch_data_i(wdata[0]),
    .ch_sel_i(sel[0]), .ch_hold_i(hold[0]),
    .ch_data_o(chDataO[0]), .ch_err_o(chErrO[0]), .ch_stallreq_o(stallO[0]),
    .wb_dat_i(wbDatI[0]), .wb_ack_i(wbAck[0]), .wb_err_i(wbErr[0]),
    .wb_adr_o(wbAdr[0]), .wb_dat_o(wbDatO[0]), .wb_we_o(wbWe[0]), .wb_sel_o(wbSel[0]),
    .wb_stb_o(wbStb[0]), .wb_cyc_o(wbCyc[0])
  );

  wb_multi_bus_if #(.NCH(NCH), .AW(AW), .DW(DW), .PRIO_MODE(1), .TO_CYC(TO)) dutRr (
    .clk(clk), .rst(rst), .flush_i(flush[1]),
    .ch_ce_i(ce[1]), .ch_we_i(we[1]), .ch_addr_i(addr[1]), .ch_data_i(wdata[1]),
    .ch_sel_i(sel[1]), .ch_hold_i(hold[1]),
    .ch_data_o(chDataO[1]), .ch_err_o(chErrO[1]), .ch_stallreq_o(stallO[1]),
    .wb_dat_i(wbDatI[1]), .wb_ack_i(wbAck[1]), .wb_err_i(wbErr[1]),
    .wb_adr_o(wbAdr[1]), .wb_dat_o(wbDatO[1]), .wb_we_o(wbWe[1]), .wb_sel_o(wbSel[1]),
    .wb_stb_o(wbStb[1]), .wb_cyc_o(wbCyc[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: run did not reach its summary");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compCnt++;
    assert (obs === exp) else begin
      errCnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int d, input int c, input logic weV, input logic [AW-1:0] adrV,
                               input logic [DW-1:0] datV, input logic [SW-1:0] selV);
    we[d][c]              = weV;
    addr[d][c*AW +: AW]   = adrV;
    wdata[d][c*DW +: DW]  = datV;
    sel[d][c*SW +: SW]    = selV;
    ce[d][c]              = 1'b1;
  endtask

  task automatic checkBusStable(input int d, input logic [AW-1:0] eAdr, input logic [DW-1:0] eDat,
                                input logic eWe, input logic [SW-1:0] eSel);
    checkOutput("wb_cyc", wbCyc[d], 1'b1);
    checkOutput("wb_stb", wbStb[d], 1'b1);
    checkOutput("wb_adr", wbAdr[d], eAdr);
    checkOutput("wb_dat", wbDatO[d], eDat);
    checkOutput("wb_we", wbWe[d], eWe);
    checkOutput("wb_sel", wbSel[d], eSel);
  endtask

  // Waits for the bus cycle of channel ch, terminates it as 'kind' and checks the completion.
  task automatic serveOne(input int d, input int ch, input int kind, input int dly,
                          input logic [DW-1:0] rsp, input int maxWait, input bit dropCe);
    logic [AW-1:0] eAdr;
    logic [DW-1:0] eDat;
    logic          eWe;
    logic [SW-1:0] eSel;
    logic [DW-1:0] expD;
    bit            seen;
    eAdr = addr[d][ch*AW +: AW];
    eDat = wdata[d][ch*DW +: DW];
    eWe  = we[d][ch];
    eSel = sel[d][ch*SW +: SW];
    seen = 1'b0;
    for (int w = 0; w < maxWait && !seen; w++) begin
      @(negedge clk);
      seen = wbCyc[d];
    end
    checkOutput("cyc_start", seen, 1'b1);
    if (!seen) return;
    checkBusStable(d, eAdr, eDat, eWe, eSel);
    addr[d][ch*AW +: AW]  = AW'($urandom);
    wdata[d][ch*DW +: DW] = DW'($urandom);
    sel[d][ch*SW +: SW]   = SW'($urandom);
    we[d][ch]             = 1'($urandom);
    if (kind == K_TO) begin
      repeat (TO - 1) begin
        @(negedge clk);
        checkBusStable(d, eAdr, eDat, eWe, eSel);
      end
    end else begin
      repeat (dly - 1) begin
        @(negedge clk);
        checkBusStable(d, eAdr, eDat, eWe, eSel);
      end
      wbDatI[d] = rsp;
      if (kind == K_ACK) wbAck[d] = 1'b1;
      else               wbErr[d] = 1'b1;
    end
    @(negedge clk);
    wbAck[d] = 1'b0;
    wbErr[d] = 1'b0;
    expD = (kind != K_ACK) ? '0 : (eWe ? expData[d][ch] : rsp);
    checkOutput("done_cyc_low", wbCyc[d], 1'b0);
    checkOutput("done_stb_low", wbStb[d], 1'b0);
    checkOutput("done_stallreq", stallO[d][ch], 1'b0);
    checkOutput("done_err", chErrO[d][ch], (kind != K_ACK));
    checkOutput("done_data", chDataO[d][ch*DW +: DW], expD);
    expData[d][ch] = expD;
    lastServed[d]  = ch;
    if (dropCe) ce[d][ch] = 1'b0;
  endtask

  initial begin
    int order[$];
    int setBits;
    int r;
    compCnt = 0;
    errCnt  = 0;
    rst     = 1'b1;
    for (int d = 0; d < 2; d++) begin
      flush[d] = 1'b0; ce[d] = '0; we[d] = '0; addr[d] = '0; wdata[d] = '0;
      sel[d] = '0; hold[d] = '0; wbDatI[d] = '0; wbAck[d] = 1'b0; wbErr[d] = 1'b0;
      lastServed[d] = NCH - 1;
      for (int c = 0; c < NCH; c++) expData[d][c] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput("rst_cyc", wbCyc[d], 1'b0);
      checkOutput("rst_stb", wbStb[d], 1'b0);
      checkOutput("rst_we", wbWe[d], 1'b0);
      checkOutput("rst_sel", wbSel[d], '0);
      checkOutput("rst_adr", wbAdr[d], '0);
      checkOutput("rst_dat", wbDatO[d], '0);
      checkOutput("rst_err", chErrO[d], '0);
      checkOutput("rst_stall", stallO[d], '0);
      for (int c = 0; c < NCH; c++) checkOutput("rst_data", chDataO[d][c*DW +: DW], '0);
    end
    rst = 1'b0;

    $display("[TB] single read ch0");
    @(negedge clk);
    applyStimulus(0, 0, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
    serveOne(0, 0, K_ACK, 2, 32'hDEAD_BEEF, 1, 1'b1);

    $display("[TB] held pipeline ch0");
    @(negedge clk);
    applyStimulus(0, 0, 1'b0, 32'h0000_2000, 32'h0, 4'hF);
    serveOne(0, 0, K_ACK, 1, 32'hCAFE_0001, 1, 1'b0);
    hold[0][0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("hold_no_cyc", wbCyc[0], 1'b0);
      checkOutput("hold_stall", stallO[0][0], 1'b0);
      checkOutput("hold_data", chDataO[0][0 +: DW], expData[0][0]);
    end
    hold[0][0] = 1'b0;
    @(negedge clk);
    checkOutput("hold_release_stall", stallO[0][0], 1'b1);
    checkOutput("hold_release_cyc", wbCyc[0], 1'b0);
    serveOne(0, 0, K_ACK, 1, 32'h0BAD_F00D, 1, 1'b1);

    $display("[TB] fixed-priority contention");
    @(negedge clk);
    applyStimulus(0, 1, 1'b0, 32'h0000_3004, 32'h0, 4'hF);
    applyStimulus(0, 0, 1'b0, 32'h0000_3000, 32'h0, 4'hF);
    serveOne(0, 0, K_ACK, 2, 32'h1111_0000, 1, 1'b1);
    checkOutput("contend_ch1_stall", stallO[0][1], 1'b1);
    serveOne(0, 1, K_ACK, 1, 32'h2222_0001, 1, 1'b1);

    $display("[TB] round-robin contention");
    for (int rep = 0; rep < 2; rep++) begin
      @(negedge clk);
      applyStimulus(1, 0, 1'b0, 32'h0000_4000, 32'h0, 4'hF);
      applyStimulus(1, 1, 1'b0, 32'h0000_4004, 32'h0, 4'hF);
      serveOne(1, 0, K_ACK, 1, DW'($urandom), 1, 1'b1);
      checkOutput("rr_ch1_stall", stallO[1][1], 1'b1);
      serveOne(1, 1, K_ACK, 1, DW'($urandom), 1, 1'b1);
    end

    $display("[TB] flush mid-access");
    @(negedge clk);
    applyStimulus(0, 0, 1'b0, 32'h0000_5000, 32'h0, 4'hF);
    @(negedge clk);
    checkOutput("flush_cyc_start", wbCyc[0], 1'b1);
    @(negedge clk);
    flush[0]  = 1'b1;
    wbAck[0]  = 1'b1;
    wbDatI[0] = 32'h5555_5555;
    @(negedge clk);
    flush[0] = 1'b0;
    wbAck[0] = 1'b0;
    checkOutput("flush_cyc_low", wbCyc[0], 1'b0);
    checkOutput("flush_data_kept", chDataO[0][0 +: DW], expData[0][0]);
    checkOutput("flush_not_done", stallO[0][0], 1'b1);
    checkOutput("flush_err", chErrO[0][0], 1'b0);
    serveOne(0, 0, K_ACK, 1, 32'h6666_7777, 1, 1'b1);

    $display("[TB] timeout and bus error");
    @(negedge clk);
    applyStimulus(0, 2, 1'b0, 32'h0000_6000, 32'h0, 4'hF);
    serveOne(0, 2, K_TO, 1, 32'h0, 1, 1'b1);
    @(negedge clk);
    checkOutput("timeout_err_cleared", chErrO[0][2], 1'b0);
    applyStimulus(0, 1, 1'b0, 32'h0000_6004, 32'h0, 4'hF);
    serveOne(0, 1, K_ERR, 3, 32'h7777_8888, 1, 1'b1);

    $display("[TB] write ch1");
    @(negedge clk);
    applyStimulus(0, 1, 1'b1, 32'h0000_7000, 32'h1234_5678, 4'b0011);
    serveOne(0, 1, K_ACK, 3, 32'h9999_AAAA, 1, 1'b1);

    $display("[TB] randomized rounds");
    for (int d = 0; d < 2; d++) begin
      for (int rnd = 0; rnd < 12; rnd++) begin
        @(negedge clk);
        setBits = int'($urandom_range(1, (1 << NCH) - 1));
        for (int c = 0; c < NCH; c++) begin
          if (setBits[c]) applyStimulus(d, c, 1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom));
        end
        order.delete();
        if (d == 0) begin
          for (int c = 0; c < NCH; c++) if (setBits[c]) order.push_back(c);
        end else begin
          for (int i = 1; i <= NCH; i++) begin
            if (setBits[(lastServed[d] + i) % NCH]) order.push_back((lastServed[d] + i) % NCH);
          end
        end
        for (int k = 0; k < order.size(); k++) begin
          r = int'($urandom_range(0, 99));
          serveOne(d, order[k], (r < 70) ? K_ACK : ((r < 85) ? K_ERR : K_TO),
                   int'($urandom_range(1, TO)), DW'($urandom), 3, 1'b1);
          for (int j = k + 1; j < order.size(); j++) checkOutput("pending_stall", stallO[d][order[j]], 1'b1);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, errCnt);
    $finish;
  end

endmodule
